// File: rtl/srt_rx_buffer_pkg.sv
// Shared constants and the handshake state encoding for the serial receive buffer.
package srt_pkg;

    localparam int DATA_W       = 8;
    localparam int DEPTH_DEF    = 8;
    localparam int ERRCNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } srt_state_e;

endpackage

// File: rtl/srt_rx_buffer_if.sv
// Receiver handshake plus host read/statistics bus of the receive buffer.
interface srt_rx_buffer_if #(
    parameter int ADDR_W   = 3,
    parameter int ERRCNT_W = 8
);
    import srt_pkg::*;

    logic                  dry;
    logic                  err;
    logic [0:DATA_W-1]     q;
    logic                  ack;
    logic                  rd;
    logic [0:DATA_W-1]     dout;
    logic                  empty;
    logic                  full;
    logic [ADDR_W:0]       count;
    logic                  ovf;
    logic [ERRCNT_W-1:0]   err_cnt;
    logic                  clr;

    modport master (
        output dry, err, q, rd, clr,
        input  ack, dout, empty, full, count, ovf, err_cnt
    );

    modport slave (
        input  dry, err, q, rd, clr,
        output ack, dout, empty, full, count, ovf, err_cnt
    );

endinterface

// File: rtl/srt_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is always visible on dout.
module srt_sync_fifo
    import srt_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [0:DATA_W-1]   din,
    input  logic                rd_en,
    output logic [0:DATA_W-1]   dout,
    output logic                empty,
    output logic                full,
    output logic [ADDR_W:0]     count
);

    logic [0:DATA_W-1] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              pop;
    logic              push;

    assign empty = (count_q == '0);
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A full FIFO still takes a write when the same edge frees a slot.
    always_comb begin
        pop      = rd_en && !empty;
        push     = wr_en && (!full || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/srt_rx_buffer.sv
// Receive buffer: DRY/ACK handshake, error filtering, FIFO capture and sticky statistics.
module srt_rx_buffer
    import srt_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = 3,
    parameter int ERRCNT_W = ERRCNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    srt_rx_buffer_if.slave  bus
);

    srt_state_e            state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  ovf_q, ovf_d;
    logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                  capture;
    logic                  can_accept;
    logic                  wr_en;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ADDR_W:0]       fifo_count;
    logic [0:DATA_W-1]     fifo_dout;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_LOW;
            ack_q     <= 1'b0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (bus.dry) state_d = ACK;
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!bus.dry) state_d = IDLE;
            default:  state_d = WAIT_LOW;
        endcase
    end

    // clr wins over a coincident statistics event; the FIFO write is unaffected.
    always_comb begin
        capture    = (state_q == IDLE) && bus.dry;
        can_accept = !fifo_full || (bus.rd && !fifo_empty);
        wr_en      = capture && !bus.err && can_accept;
        ack_d      = (state_d == ACK);
        ovf_d      = ovf_q;
        err_cnt_d  = err_cnt_q;
        if (bus.clr) begin
            ovf_d     = 1'b0;
            err_cnt_d = '0;
        end else if (capture) begin
            if (bus.err)          err_cnt_d = sat_inc(err_cnt_q);
            else if (!can_accept) ovf_d     = 1'b1;
        end
    end

    srt_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (bus.q),
        .rd_en (bus.rd),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign bus.ack     = ack_q;
    assign bus.dout    = fifo_dout;
    assign bus.empty   = fifo_empty;
    assign bus.full    = fifo_full;
    assign bus.count   = fifo_count;
    assign bus.ovf     = ovf_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_srt_rx_buffer.sv
// Directed bench for srt_rx_buffer, with a second narrow-counter instance for saturation.
module tb_srt_rx_buffer;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   acks;

    always #5 clk = ~clk;

    srt_rx_buffer_if #(.ADDR_W(3), .ERRCNT_W(8)) b1 ();
    srt_rx_buffer_if #(.ADDR_W(3), .ERRCNT_W(2)) b2 ();

    srt_rx_buffer #(.DEPTH(8), .ADDR_W(3), .ERRCNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    srt_rx_buffer #(.DEPTH(8), .ADDR_W(3), .ERRCNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake: capture edge, drop dry, then one more edge back to IDLE.
    task automatic send(input logic [7:0] v, input logic e, input string tag);
        b1.q   = v;
        b1.err = e;
        b1.dry = 1'b1;
        tick();
        check({tag, "_ack"}, int'(b1.ack), 1);
        b1.dry = 1'b0;
        b1.err = 1'b0;
        tick();
        check({tag, "_ack_drop"}, int'(b1.ack), 0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        b1.dry = 0; b1.err = 0; b1.q = '0; b1.rd = 0; b1.clr = 0;
        b2.dry = 0; b2.err = 0; b2.q = '0; b2.rd = 0; b2.clr = 0;
        tick();
        tick();
        check("rst_ack",     int'(b1.ack), 0);
        check("rst_empty",   int'(b1.empty), 1);
        check("rst_full",    int'(b1.full), 0);
        check("rst_count",   int'(b1.count), 0);
        check("rst_ovf",     int'(b1.ovf), 0);
        check("rst_err_cnt", int'(b1.err_cnt), 0);
        rst = 1'b0;
        tick();

        // Single byte with dry held for four cycles
        b1.q = 8'hA5; b1.dry = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            acks += int'(b1.ack);
            if (i == 0) check("one_ack_first", int'(b1.ack), 1);
        end
        check("one_ack_pulses", acks, 1);
        check("one_count", int'(b1.count), 1);
        check("one_dout",  int'(b1.dout), 8'hA5);
        check("one_empty", int'(b1.empty), 0);
        b1.dry = 1'b0;
        tick();
        b1.rd = 1'b1;
        tick();
        b1.rd = 1'b0;
        check("one_drain", int'(b1.count), 0);

        // Four bytes in, read back in order
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, "seq");
        check("seq_count", int'(b1.count), 4);
        for (int i = 1; i <= 4; i++) begin
            check("seq_dout", int'(b1.dout), i);
            b1.rd = 1'b1;
            tick();
        end
        check("seq_empty", int'(b1.empty), 1);
        tick();
        check("seq_extra_rd", int'(b1.count), 0);
        b1.rd = 1'b0;

        // Fill, overflow, then write-while-full with a coincident pop
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0, "fill");
        check("fill_full",  int'(b1.full), 1);
        check("fill_count", int'(b1.count), 8);
        send(8'hFF, 1'b0, "ovf");
        check("ovf_flag",  int'(b1.ovf), 1);
        check("ovf_count", int'(b1.count), 8);
        check("ovf_head",  int'(b1.dout), 8'h10);
        b1.clr = 1'b1;
        tick();
        b1.clr = 1'b0;
        check("ovf_clr", int'(b1.ovf), 0);
        b1.q = 8'hEE; b1.dry = 1'b1; b1.rd = 1'b1;
        tick();
        check("fullpop_ack",   int'(b1.ack), 1);
        check("fullpop_ovf",   int'(b1.ovf), 0);
        check("fullpop_count", int'(b1.count), 8);
        check("fullpop_head",  int'(b1.dout), 8'h11);
        b1.dry = 1'b0; b1.rd = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check("fullpop_drain", int'(b1.dout), (i < 7) ? (8'h11 + i) : 8'hEE);
            b1.rd = 1'b1;
            tick();
            b1.rd = 1'b0;
        end
        check("fullpop_empty", int'(b1.empty), 1);

        // Error bytes are counted, not stored
        for (int i = 0; i < 3; i++) send(8'h99, 1'b1, "errb");
        check("err_count",   int'(b1.count), 0);
        check("err_err_cnt", int'(b1.err_cnt), 3);
        for (int i = 0; i < 5; i++) begin
            b2.q = 8'h55; b2.err = 1'b1; b2.dry = 1'b1;
            tick();
            b2.dry = 1'b0; b2.err = 1'b0;
            tick();
            tick();
        end
        check("sat_err_cnt", int'(b2.err_cnt), 3);
        check("sat_count",   int'(b2.count), 0);
        b1.q = 8'h77; b1.err = 1'b1; b1.dry = 1'b1; b1.clr = 1'b1;
        tick();
        check("clr_err_cnt", int'(b1.err_cnt), 0);
        check("clr_ack",     int'(b1.ack), 1);
        b1.clr = 1'b0; b1.dry = 1'b0; b1.err = 1'b0;
        tick();
        tick();

        // Reset while in ACK with dry held high
        b1.q = 8'h33; b1.dry = 1'b1;
        tick();
        check("rstack_ack_pre",   int'(b1.ack), 1);
        check("rstack_count_pre", int'(b1.count), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstack_ack",   int'(b1.ack), 0);
        check("rstack_count", int'(b1.count), 0);
        tick();
        tick();
        check("rstack_norecap_count", int'(b1.count), 0);
        check("rstack_norecap_ack",   int'(b1.ack), 0);
        b1.dry = 1'b0;
        tick();
        b1.q = 8'h44; b1.dry = 1'b1;
        tick();
        check("rstack_recap_ack",   int'(b1.ack), 1);
        check("rstack_recap_count", int'(b1.count), 1);
        check("rstack_recap_dout",  int'(b1.dout), 8'h44);
        b1.dry = 1'b0;
        tick();
        tick();

        // Simultaneous write and pop at count=1
        b1.q = 8'h5A; b1.dry = 1'b1; b1.rd = 1'b1;
        tick();
        b1.dry = 1'b0; b1.rd = 1'b0;
        check("wrpop_count", int'(b1.count), 1);
        check("wrpop_dout",  int'(b1.dout), 8'h5A);
        check("wrpop_empty", int'(b1.empty), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
